// File: rtl/move_arbiter_if.sv
// Board-side bundle for move_arbiter: switch/occupancy inputs in, store strobes and status out.
interface move_arbiter_if;
  logic [8:0] cuadro;
  logic       randomClick;
  logic       enable;
  logic       turnoX;
  logic [8:0] x;
  logic [8:0] o;
  logic [8:0] almacenar_x;
  logic [8:0] almacenar_o;
  logic       move_ok;
  logic       move_bad;
  logic       busy;

  modport master (
    output cuadro, randomClick, enable, turnoX, x, o,
    input  almacenar_x, almacenar_o, move_ok, move_bad, busy
  );

  modport slave (
    input  cuadro, randomClick, enable, turnoX, x, o,
    output almacenar_x, almacenar_o, move_ok, move_bad, busy
  );
endinterface

// File: rtl/move_arbiter.sv
// Turns a human square press or an automatic-move request into a single one-hot store strobe
// for X or O, rejecting occupied/ambiguous presses and full boards.
module move_arbiter (
  input  logic          clk,
  input  logic          reset,
  move_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSearch, StCommit, StSettle} state_e;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] probe_q, probe_d;
  logic [3:0] try_q, try_d;
  logic [8:0] cuadro_q, cuadro_d;
  logic       rand_q, rand_d;
  logic [8:0] sq_q, sq_d;
  logic       turn_q, turn_d;
  logic       bad_q, bad_d;

  logic [8:0] cuadro_rise;
  logic       rand_rise;
  logic [8:0] occ;
  logic [8:0] probe_oh;
  logic       one_hot;
  logic       probe_free;

  assign cuadro_rise = bus.cuadro & ~cuadro_q;
  assign rand_rise   = bus.randomClick & ~rand_q;
  assign occ         = bus.x | bus.o;
  assign probe_oh    = 9'd1 << probe_q;
  assign one_hot     = (cuadro_rise != '0) && ((cuadro_rise & (cuadro_rise - 9'd1)) == '0);
  assign probe_free  = (probe_oh & occ) == '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      probe_q  <= '0;
      try_q    <= '0;
      cuadro_q <= '0;
      rand_q   <= 1'b0;
      sq_q     <= '0;
      turn_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      probe_q  <= probe_d;
      try_q    <= try_d;
      cuadro_q <= cuadro_d;
      rand_q   <= rand_d;
      sq_q     <= sq_d;
      turn_q   <= turn_d;
      bad_q    <= bad_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
    probe_d  = probe_q;
    try_d    = try_q;
    cuadro_d = bus.cuadro;
    rand_d   = bus.randomClick;
    sq_d     = sq_q;
    turn_d   = turn_q;
    bad_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          // A square press outranks a simultaneous random request.
          if (cuadro_rise != '0) begin
            if (one_hot && ((cuadro_rise & occ) == '0)) begin
              sq_d    = cuadro_rise;
              turn_d  = bus.turnoX;
              state_d = StCommit;
            end else begin
              bad_d = 1'b1;
            end
          end else if (rand_rise) begin
            probe_d = idx_q;
            turn_d  = bus.turnoX;
            try_d   = '0;
            state_d = StSearch;
          end
        end
      end
      StSearch: begin
        if (!bus.enable) begin
          state_d = StIdle;
        end else if (probe_free) begin
          sq_d    = probe_oh;
          state_d = StCommit;
        end else if (try_q == 4'd8) begin
          // Ninth occupied probe: every square has been visited.
          bad_d   = 1'b1;
          state_d = StIdle;
        end else begin
          probe_d = (probe_q == 4'd8) ? 4'd0 : probe_q + 4'd1;
          try_d   = try_q + 4'd1;
        end
      end
      StCommit: state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.almacenar_x = '0;
    bus.almacenar_o = '0;
    bus.move_ok     = 1'b0;
    bus.move_bad    = bad_q;
    bus.busy        = (state_q != StIdle);
    if (state_q == StCommit) begin
      bus.move_ok = 1'b1;
      if (turn_q) bus.almacenar_x = sq_q;
      else        bus.almacenar_o = sq_q;
    end
  end

endmodule

// File: tb/tb_move_arbiter.sv
// Directed table plus hand sequences for move_arbiter; outputs sampled on the falling edge.
module tb_move_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  move_arbiter_if bus ();

  move_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // {almacenar_x, almacenar_o, move_ok, move_bad, busy}
  logic [20:0] outs;
  assign outs = {bus.almacenar_x, bus.almacenar_o, bus.move_ok, bus.move_bad, bus.busy};

  function automatic logic [20:0] ex(logic [8:0] ax, logic [8:0] ao, logic ok, logic bad,
                                     logic bsy);
    return {ax, ao, ok, bad, bsy};
  endfunction

  task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got ax=%h ao=%h ok=%b bad=%b busy=%b, want ax=%h ao=%h ok=%b bad=%b busy=%b",
               name, act[20:12], act[11:3], act[2], act[1], act[0],
               exp[20:12], exp[11:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [8:0] c, input logic r, input logic en, input logic tx,
                       input logic [8:0] xv, input logic [8:0] ov);
    bus.cuadro      = c;
    bus.randomClick = r;
    bus.enable      = en;
    bus.turnoX      = tx;
    bus.x           = xv;
    bus.o           = ov;
  endtask

  // Leaves the bench at a falling edge with reset just released; idx is 0 at the next rise.
  task automatic do_reset(input logic [8:0] c_hold);
    @(negedge clk);
    reset = 1'b0;
    drive(c_hold, 1'b0, 1'b1, 1'b1, 9'h000, 9'h000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [8:0]  cuadro;
    logic        rnd;
    logic        en;
    logic        tx;
    logic [8:0]  x;
    logic [8:0]  o;
    logic [20:0] exp;
  } vec_t;

  vec_t tv[18];

  initial begin
    tv[0]  = '{9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 9'h000, ex(9'h000, 9'h000, 0, 0, 0)};
    tv[1]  = '{9'h010, 1'b0, 1'b1, 1'b1, 9'h000, 9'h000, ex(9'h010, 9'h000, 1, 0, 1)};
    tv[2]  = '{9'h010, 1'b0, 1'b1, 1'b0, 9'h010, 9'h000, ex(9'h000, 9'h000, 0, 0, 1)};
    tv[3]  = '{9'h000, 1'b0, 1'b1, 1'b0, 9'h010, 9'h000, ex(9'h000, 9'h000, 0, 0, 0)};
    tv[4]  = '{9'h000, 1'b0, 1'b1, 1'b0, 9'h001, 9'h000, ex(9'h000, 9'h000, 0, 0, 0)};
    tv[5]  = '{9'h001, 1'b0, 1'b1, 1'b0, 9'h001, 9'h000, ex(9'h000, 9'h000, 0, 1, 0)};
    tv[6]  = '{9'h000, 1'b0, 1'b1, 1'b0, 9'h001, 9'h000, ex(9'h000, 9'h000, 0, 0, 0)};
    tv[7]  = '{9'h003, 1'b0, 1'b1, 1'b1, 9'h000, 9'h000, ex(9'h000, 9'h000, 0, 1, 0)};
    tv[8]  = '{9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 9'h000, ex(9'h000, 9'h000, 0, 0, 0)};
    tv[9]  = '{9'h100, 1'b0, 1'b0, 1'b1, 9'h000, 9'h000, ex(9'h000, 9'h000, 0, 0, 0)};
    tv[10] = '{9'h100, 1'b0, 1'b1, 1'b1, 9'h000, 9'h000, ex(9'h000, 9'h000, 0, 0, 0)};
    tv[11] = '{9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 9'h000, ex(9'h000, 9'h000, 0, 0, 0)};
    tv[12] = '{9'h100, 1'b1, 1'b1, 1'b0, 9'h000, 9'h000, ex(9'h000, 9'h100, 1, 0, 1)};
    tv[13] = '{9'h100, 1'b1, 1'b1, 1'b1, 9'h000, 9'h100, ex(9'h000, 9'h000, 0, 0, 1)};
    tv[14] = '{9'h000, 1'b1, 1'b1, 1'b1, 9'h000, 9'h100, ex(9'h000, 9'h000, 0, 0, 0)};
    tv[15] = '{9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 9'h100, ex(9'h000, 9'h000, 0, 0, 0)};
    tv[16] = '{9'h004, 1'b0, 1'b1, 1'b1, 9'h000, 9'h004, ex(9'h000, 9'h000, 0, 1, 0)};
    tv[17] = '{9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 9'h004, ex(9'h000, 9'h000, 0, 0, 0)};

    drive(9'h000, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000);
    #1;
    chk("reset_state_async", outs, '0);
    @(negedge clk);
    chk("reset_state_clocked", outs, '0);

    // Table: each vector is consumed by one rising edge, result checked at the next fall.
    do_reset(9'h000);
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].cuadro, tv[i].rnd, tv[i].en, tv[i].tx, tv[i].x, tv[i].o);
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs, tv[i].exp);
    end

    // Random move, idx=3, squares 3..5 taken by X: O lands on square 6 in cycle 5.
    do_reset(9'h000);
    drive(9'h000, 1'b0, 1'b1, 1'b0, 9'h038, 9'h000);
    repeat (3) @(negedge clk);
    bus.randomClick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c < 5)       chk($sformatf("rand_skip_c%0d", c), outs, ex(0, 0, 0, 0, 1));
      else if (c == 5) chk("rand_skip_commit", outs, ex(9'h000, 9'h040, 1, 0, 1));
      else             chk("rand_skip_settle", outs, ex(0, 0, 0, 0, 1));
    end
    bus.randomClick = 1'b0;

    // Full board: nine SEARCH cycles, then move_bad with no strobe.
    do_reset(9'h000);
    drive(9'h000, 1'b0, 1'b1, 1'b1, 9'h155, 9'h0AA);
    @(negedge clk);
    bus.randomClick = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c <= 9)       chk($sformatf("full_search_c%0d", c), outs, ex(0, 0, 0, 0, 1));
      else if (c == 10) chk("full_bad", outs, ex(0, 0, 0, 1, 0));
      else              chk("full_after", outs, ex(0, 0, 0, 0, 0));
    end
    bus.randomClick = 1'b0;

    // Reset in SEARCH: a free square ahead must never be committed.
    do_reset(9'h000);
    drive(9'h000, 1'b0, 1'b1, 1'b0, 9'h038, 9'h000);
    repeat (3) @(negedge clk);
    bus.randomClick = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_in_search", outs, ex(0, 0, 0, 0, 1));
    reset = 1'b0;
    bus.randomClick = 1'b0;
    #1;
    chk("rst_mid_async", outs, '0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_quiet_c%0d", c), outs, '0);
    end

    // Switch held through reset counts as a press on the first clock.
    do_reset(9'h002);
    @(negedge clk);
    chk("held_switch_commit", outs, ex(9'h002, 9'h000, 1, 0, 1));
    @(negedge clk);
    chk("held_switch_settle", outs, ex(0, 0, 0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Any cycle with more than one strobe bit across both buses is an error.
  always @(negedge clk) begin
    if (reset && ($countones({bus.almacenar_x, bus.almacenar_o}) > 1)) begin
      nvec++;
      nerr++;
      $display("FAIL strobe_onehot: got ax=%h ao=%h, want at most one bit",
               bus.almacenar_x, bus.almacenar_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
